// File: rtl/if_id_elastic.sv
// IF/ID pipeline register with valid/ready handshakes on both sides.
// A 2-entry skid buffer (main + skid) keeps up_ready registered while
// sustaining one transfer per cycle under decode backpressure. A synchronous
// flush squashes every held entry for branch/redirect.
// Optional macro IF_ID_PERF_EN adds saturating stall/bubble counters.
module if_id_elastic #(
  parameter int              PC_W     = 16,
  parameter int              IR_W     = 16,
  parameter logic [PC_W-1:0] FLUSH_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            up_valid,
  output logic            up_ready,
  input  logic [PC_W-1:0] pc_in,
  input  logic [IR_W-1:0] ir_in,
  output logic            dn_valid,
  input  logic            dn_ready,
  input  logic            flush,
  output logic [PC_W-1:0] pc_out,
  output logic [3:0]      opcode,
  output logic [2:0]      dest,
  output logic [2:0]      src1,
  output logic [2:0]      src2,
  output logic [10:0]     ir_10_0
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            up_ready_q, up_ready_d;
  logic            dn_valid_q, dn_valid_d;
  logic [PC_W-1:0] main_pc_q, main_pc_d;
  logic [IR_W-1:0] main_ir_q, main_ir_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;
  logic [IR_W-1:0] skid_ir_q, skid_ir_d;
  logic            push;
  logic            pop;

  assign push = up_valid & up_ready_q;
  assign pop  = dn_valid_q & dn_ready;

  // Next-state and datapath selection for the skid buffer.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    main_pc_d = main_pc_q;
    main_ir_d = main_ir_q;
    skid_pc_d = skid_pc_q;
    skid_ir_d = skid_ir_q;

    if (flush) begin
      state_d   = ST_EMPTY;
      main_pc_d = FLUSH_PC;
      main_ir_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_pc_d = pc_in;
            main_ir_d = ir_in;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_pc_d = pc_in;
            main_ir_d = ir_in;
          end else if (push) begin
            skid_pc_d = pc_in;
            skid_ir_d = ir_in;
            state_d   = ST_FULL;
          end else if (pop) begin
            main_pc_d = FLUSH_PC;
            main_ir_d = '0;
            state_d   = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_pc_d = skid_pc_q;
            main_ir_d = skid_ir_q;
            state_d   = ST_ONE;
          end
        end
        default: begin
          state_d   = ST_EMPTY;
          main_pc_d = FLUSH_PC;
          main_ir_d = '0;
        end
      endcase
    end

    // Handshake flags are derived from the next state so they can be registered.
    up_ready_d = (state_d != ST_FULL);
    dn_valid_d = (state_d != ST_EMPTY);
  end

  // Control state and head entry, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
      main_pc_q  <= FLUSH_PC;
      main_ir_q  <= '0;
    end else begin
      state_q    <= state_d;
      up_ready_q <= up_ready_d;
      dn_valid_q <= dn_valid_d;
      main_pc_q  <= main_pc_d;
      main_ir_q  <= main_ir_d;
    end
  end

  // Skid payload storage.
  always_ff @(posedge clk) begin
    // NOTE: skid data is only read in FULL, so it is deliberately left unreset.
    skid_pc_q <= skid_pc_d;
    skid_ir_q <= skid_ir_d;
  end

  assign up_ready = up_ready_q;
  assign dn_valid = dn_valid_q;
  assign pc_out   = main_pc_q;
  assign opcode   = main_ir_q[15:12];
  assign dest     = main_ir_q[11:9];
  assign src1     = main_ir_q[8:6];
  assign src2     = main_ir_q[2:0];
  assign ir_10_0  = main_ir_q[10:0];

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] bubble_q, bubble_d;

  // Saturating stall/bubble counters; flush leaves them untouched.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (dn_valid_q && !dn_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
    if (!dn_valid_q && dn_ready && (bubble_q != 32'hFFFF_FFFF)) begin
      bubble_d = bubble_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_if_id_elastic.sv
// Self-checking bench for if_id_elastic: directed vector table, then
// randomized traffic checked against a queue-based reference model.
module tb_if_id_elastic;

  localparam logic [15:0] FP = 16'h0BAD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up_valid;
  logic        up_ready;
  logic [15:0] pc_in;
  logic [15:0] ir_in;
  logic        dn_valid;
  logic        dn_ready;
  logic        flush;
  logic [15:0] pc_out;
  logic [3:0]  opcode;
  logic [2:0]  dest;
  logic [2:0]  src1;
  logic [2:0]  src2;
  logic [10:0] ir_10_0;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
`endif

  if_id_elastic #(.PC_W(16), .IR_W(16), .FLUSH_PC(FP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .pc_in    (pc_in),
    .ir_in    (ir_in),
    .dn_valid (dn_valid),
    .dn_ready (dn_ready),
    .flush    (flush),
    .pc_out   (pc_out),
    .opcode   (opcode),
    .dest     (dest),
    .src1     (src1),
    .src2     (src2),
    .ir_10_0  (ir_10_0)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a 2-deep FIFO of {pc, ir} words.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
  } word_t;

  word_t       mq[$];
  logic        m_up_ready = 1'b1;
  logic [31:0] m_stall    = 0;
  logic [31:0] m_bubble   = 0;

  // Apply one cycle of inputs, advance the model across the edge, compare.
  task automatic cycle(input logic uv, input logic [15:0] pc, input logic [15:0] ir,
                       input logic dr, input logic fl, input logic rn);
    logic do_push;
    logic do_pop;
    word_t w;
    up_valid = uv;
    pc_in    = pc;
    ir_in    = ir;
    dn_ready = dr;
    flush    = fl;
    rst_n    = rn;
    do_push  = uv && m_up_ready;
    do_pop   = (mq.size() > 0) && dr;
    @(posedge clk);
    if (!rn) begin
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if ((mq.size() > 0) && !dr && m_stall != 32'hFFFF_FFFF) m_stall++;
      if ((mq.size() == 0) && dr && m_bubble != 32'hFFFF_FFFF) m_bubble++;
    end
    if (!rn || fl) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        w.pc = pc;
        w.ir = ir;
        mq.push_back(w);
      end
    end
    m_up_ready = (mq.size() < 2);
    #1;
    compare_model();
  endtask

  task automatic compare_model();
    logic [15:0] e_pc;
    logic [15:0] e_ir;
    e_pc = (mq.size() > 0) ? mq[0].pc : FP;
    e_ir = (mq.size() > 0) ? mq[0].ir : 16'h0000;
    check("dn_valid", {31'd0, dn_valid}, {31'd0, mq.size() > 0});
    check("up_ready", {31'd0, up_ready}, {31'd0, m_up_ready});
    check("pc_out",   {16'd0, pc_out},   {16'd0, e_pc});
    check("opcode",   {28'd0, opcode},   {28'd0, e_ir[15:12]});
    check("dest",     {29'd0, dest},     {29'd0, e_ir[11:9]});
    check("src1",     {29'd0, src1},     {29'd0, e_ir[8:6]});
    check("src2",     {29'd0, src2},     {29'd0, e_ir[2:0]});
    check("ir_10_0",  {21'd0, ir_10_0},  {21'd0, e_ir[10:0]});
  endtask

  typedef struct {
    logic        uv;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        dr;
    logic        fl;
    logic        rn;
    logic        e_dv;
    logic        e_ur;
    logic [15:0] e_pc;
    logic [15:0] e_ir;
  } vec_t;

  vec_t vecs[22];

  initial begin
    // Streaming with dn_ready held high.
    vecs[0]  = '{1, 16'h3000, 16'h1283, 1, 0, 1, 1, 1, 16'h3000, 16'h1283};
    vecs[1]  = '{1, 16'h3002, 16'h5042, 1, 0, 1, 1, 1, 16'h3002, 16'h5042};
    vecs[2]  = '{1, 16'h3004, 16'h0E05, 1, 0, 1, 1, 1, 16'h3004, 16'h0E05};
    vecs[3]  = '{1, 16'h3006, 16'h6A41, 1, 0, 1, 1, 1, 16'h3006, 16'h6A41};
    vecs[4]  = '{0, 16'h0000, 16'h0000, 1, 0, 1, 0, 1, FP,       16'h0000};
    // Backpressure: A, B fill the buffer, C is held then drained.
    vecs[5]  = '{1, 16'h3000, 16'h2111, 0, 0, 1, 1, 1, 16'h3000, 16'h2111};
    vecs[6]  = '{1, 16'h3002, 16'h3222, 0, 0, 1, 1, 0, 16'h3000, 16'h2111};
    vecs[7]  = '{1, 16'h3004, 16'h4333, 0, 0, 1, 1, 0, 16'h3000, 16'h2111};
    vecs[8]  = '{1, 16'h3004, 16'h4333, 1, 0, 1, 1, 1, 16'h3002, 16'h3222};
    vecs[9]  = '{1, 16'h3004, 16'h4333, 1, 0, 1, 1, 1, 16'h3004, 16'h4333};
    vecs[10] = '{0, 16'h0000, 16'h0000, 1, 0, 1, 0, 1, FP,       16'h0000};
    // Flush while FULL with up_valid high, then flush in ONE with a push.
    vecs[11] = '{1, 16'h3100, 16'h7A5C, 0, 0, 1, 1, 1, 16'h3100, 16'h7A5C};
    vecs[12] = '{1, 16'h3102, 16'h8B6D, 0, 0, 1, 1, 0, 16'h3100, 16'h7A5C};
    vecs[13] = '{1, 16'h3104, 16'h9C7E, 0, 1, 1, 0, 1, FP,       16'h0000};
    vecs[14] = '{1, 16'h3106, 16'hAD8F, 1, 0, 1, 1, 1, 16'h3106, 16'hAD8F};
    vecs[15] = '{1, 16'h3108, 16'hBE90, 1, 1, 1, 0, 1, FP,       16'h0000};
    vecs[16] = '{0, 16'h0000, 16'h0000, 1, 0, 1, 0, 1, FP,       16'h0000};
    // Reset while FULL, then a normal push.
    vecs[17] = '{1, 16'h3200, 16'hCFA1, 0, 0, 1, 1, 1, 16'h3200, 16'hCFA1};
    vecs[18] = '{1, 16'h3202, 16'hD0B2, 0, 0, 1, 1, 0, 16'h3200, 16'hCFA1};
    vecs[19] = '{1, 16'h3204, 16'hE1C3, 0, 0, 0, 0, 1, FP,       16'h0000};
    vecs[20] = '{1, 16'h3206, 16'hF2D4, 0, 0, 1, 1, 1, 16'h3206, 16'hF2D4};
    vecs[21] = '{0, 16'h0000, 16'h0000, 1, 0, 1, 0, 1, FP,       16'h0000};

    // Reset for two cycles.
    cycle(0, 16'h0, 16'h0, 0, 0, 0);
    cycle(0, 16'h0, 16'h0, 0, 0, 0);
    check("rst_dn_valid", {31'd0, dn_valid}, 32'd0);
    check("rst_up_ready", {31'd0, up_ready}, 32'd1);
    check("rst_pc_out",   {16'd0, pc_out},   {16'd0, FP});
    check("rst_opcode",   {28'd0, opcode},   32'd0);

    for (int i = 0; i < 22; i++) begin
      cycle(vecs[i].uv, vecs[i].pc, vecs[i].ir, vecs[i].dr, vecs[i].fl, vecs[i].rn);
      check($sformatf("vec%0d_dn_valid", i), {31'd0, dn_valid}, {31'd0, vecs[i].e_dv});
      check($sformatf("vec%0d_up_ready", i), {31'd0, up_ready}, {31'd0, vecs[i].e_ur});
      check($sformatf("vec%0d_pc_out", i),   {16'd0, pc_out},   {16'd0, vecs[i].e_pc});
      check($sformatf("vec%0d_ir_10_0", i),  {21'd0, ir_10_0},  {21'd0, vecs[i].e_ir[10:0]});
      check($sformatf("vec%0d_opcode", i),   {28'd0, opcode},   {28'd0, vecs[i].e_ir[15:12]});
      if (i == 0) begin
        check("first_opcode", {28'd0, opcode},  32'd1);
        check("first_dest",   {29'd0, dest},    32'd1);
        check("first_src1",   {29'd0, src1},    32'd2);
        check("first_src2",   {29'd0, src2},    32'd3);
        check("first_ir10_0", {21'd0, ir_10_0}, 32'h283);
      end
    end

    // Fill to ONE then hold simultaneous push/pop with random dn_ready.
    cycle(1, 16'h4000, 16'h1234, 1, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 16'h4002 + 16'(2 * i), 16'($urandom), 1'($urandom_range(0, 1)), 0, 1);
    end

    // Long randomized traffic including occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 59) != 0));
`ifdef IF_ID_PERF_EN
      check("stall_cnt",  stall_cnt,  m_stall);
      check("bubble_cnt", bubble_cnt, m_bubble);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_elastic.md
Name: if_id_elastic

Overview:
- Parametrised successor of the fixed-load IF/ID pipeline register.
- Replaces the single `load` enable with a valid/ready handshake on both sides, backed by a 2-entry skid buffer, so the fetch stage sees a registered ready and the stage sustains full throughput under decode backpressure.
- Adds a synchronous flush for branch/redirect squash.
- Sits between the fetch stage and decode; drives the decoded lc3b IR fields from the head entry.

Parameters:
- PC_W, 16, width of PC payload
- IR_W, 16, width of instruction payload; decode fields are defined for IR_W = 16 only
- FLUSH_PC, 0, value driven on pc_out while empty or after flush

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- up_valid  in  1  fetch presents pc_in/ir_in
- up_ready  out  1  stage can accept; registered
- pc_in  in  PC_W  fetched PC
- ir_in  in  IR_W  fetched instruction
- dn_valid  out  1  head entry valid
- dn_ready  in  1  decode consumes head this cycle
- flush  in  1  squash all held entries
- pc_out  out  PC_W  head PC
- opcode  out  4  ir[15:12] of head
- dest  out  3  ir[11:9] of head
- src1  out  3  ir[8:6] of head
- src2  out  3  ir[2:0] of head
- ir_10_0  out  11  ir[10:0] of head

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n). All state updates on the rising edge of clk.
- Transfer definitions:
  - push = up_valid & up_ready
  - pop = dn_valid & dn_ready
- Storage: head register (main) and skid register. FSM states: EMPTY, ONE, FULL.
- EMPTY:
  - push -> main <= input; go to ONE.
- ONE:
  - push & pop -> main <= input; stay in ONE.
  - push & !pop -> skid <= input; go to FULL.
  - !push & pop -> go to EMPTY.
- FULL:
  - pop -> main <= skid; go to ONE.
  - No push is possible, since up_ready = 0.
- up_ready is a registered output: 1 in EMPTY and ONE, 0 in FULL. It is computed from the next state, so it never combinationally depends on dn_ready.
- dn_valid = (state != EMPTY), registered.
- Latency: an accepted word appears at the outputs on the cycle after the push. Order is strict FIFO. No word is lost or duplicated.
- Decode fields are combinational slices of the main IR. When EMPTY, main IR holds 16'h0000 and pc_out = FLUSH_PC.
- Flush:
  - Next state is EMPTY; main IR <= 0; pc <= FLUSH_PC; skid contents are don't-care.
  - A push in the same cycle as flush is discarded.
  - A pop in the same cycle as flush still counts as consumed by decode.
  - up_ready = 1 on the following cycle.
- Reset (rst_n = 0 at an edge), including mid-transfer or while FULL:
  - state = EMPTY; dn_valid = 0; up_ready = 1; main IR = 0; pc_out = FLUSH_PC.
  - Reset dominates flush and push.
- dn_valid = 0 with dn_ready = 1 has no effect. up_valid = 0 with up_ready = 1 has no effect.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- Defined:
  - Adds outputs stall_cnt [31:0] and bubble_cnt [31:0], both reset to 0.
  - stall_cnt increments each cycle dn_valid & !dn_ready.
  - bubble_cnt increments each cycle !dn_valid & dn_ready.
  - Flush does not clear the counters.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then streaming: hold dn_ready = 1; push pc 0x3000..0x3006 with ir 0x1283, 0x5042, 0x0E05, 0x6A41 on consecutive cycles.
  -> Each appears one cycle later in order; the first shows opcode 1, dest 1, src1 2, src2 3, ir_10_0 0x283.
  -> up_ready stays 1 throughout.
- Backpressure: dn_ready = 0; push A (0x3000), B (0x3002).
  -> FULL; up_ready = 0 from the cycle after B; C is held by fetch.
  -> Raise dn_ready: outputs A, B, C on consecutive cycles with no loss.
- Flush while FULL, with up_valid = 1 in the flush cycle.
  -> Next cycle dn_valid = 0, pc_out = FLUSH_PC, opcode = 0, up_ready = 1.
  -> The flush-cycle input never appears at the outputs.
- Reset mid-operation: assert rst_n = 0 while FULL for one cycle.
  -> dn_valid = 0, up_ready = 1, pc_out = FLUSH_PC next cycle.
  -> A push the cycle after rst_n returns to 1 emerges normally.
- Simultaneous push/pop in ONE for 8 cycles with random dn_ready.
  -> Order is preserved and dn_valid never drops while data is pending.
  -> With IF_ID_PERF_EN, stall_cnt equals the count of dn_valid & !dn_ready cycles.
